latch_fifo: RTL and testbench
=============================

LATCH_FIFO -- requirements
Module: latch_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data bits per entry (1..32).
REQ-002 Parameter DEPTH, default 4, entry count; power of two, 2..16.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 nRESET  input  1  reset; asynchronous, active-low.
REQ-005 D  input  WIDTH  latch data from host bus.
REQ-006 LE  input  1  latch enable strobe, asynchronous to CLK.
REQ-007 RD  input  1  single-cycle read-acknowledge (pop) from consumer.
REQ-008 CLR_OVR  input  1  clears sticky overrun flag.
REQ-009 nOE  input  1  output enable, active-low; drives Q_OE only.
REQ-010 Q  output  WIDTH  head-of-queue data.
REQ-011 Q_OE  output  1  high when nOE low; the top level uses it to tri-state Q onto the bidirectional bus.
REQ-012 VALID  output  1  queue non-empty.
REQ-013 FULL  output  1  queue holds DEPTH entries.
REQ-014 COUNT  output  clog2(DEPTH+1)  occupancy.
REQ-015 OVERRUN  output  1  sticky: a capture was dropped.

Function
REQ-016 LE synchronised through two CLK flops; rising edge detected as stage2 high and stage3 low.
REQ-017 Capture event asserts the cycle after the edge detect; D sampled on that edge and written to the tail; 3-4 CLK latency from LE rise to VALID.
REQ-018 D held stable from LE rise until 4 CLK cycles later; not checked by the block.
REQ-019 One capture per LE rising edge; LE held high produces no further captures.
REQ-020 Q shows the head entry combinationally from storage; Q undefined-free: Q = 0 when empty.
REQ-021 RD while VALID pops the head; next head on Q the following cycle.
REQ-022 RD while empty ignored; COUNT stays 0, no flag change.
REQ-023 Capture while not FULL: write, COUNT+1.
REQ-024 Capture and RD same cycle, non-empty: both occur, COUNT unchanged, including when FULL.
REQ-025 Capture and RD same cycle, empty: write occurs, RD ignored, COUNT becomes 1.
REQ-026 Capture while FULL without RD: data dropped, storage unchanged, OVERRUN set next edge.
REQ-027 CLR_OVR clears OVERRUN; coincident new overrun wins (flag stays set).
REQ-028 Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 FULL = (COUNT == DEPTH); VALID = (COUNT != 0); both registered-derived, no glitch paths from LE.
REQ-030 Q_OE = ~nOE, combinational; nOE does not affect queue state.

Reset
REQ-031 nRESET low asynchronously clears pointers, COUNT, OVERRUN, synchroniser flops; Q = 0, VALID = 0, FULL = 0.
REQ-032 Storage array contents need not reset; Q is masked to 0 when empty.
REQ-033 Reset mid-capture: LE edge in flight discarded; after release a new LE rising edge is required (LE high at release does not capture).
REQ-034 Reset deassertion is synchronised externally; block requires no extra release logic.

Structure
REQ-035 Shared package latch_pkg holds default WIDTH/DEPTH constants and a clog2 function.
REQ-036 One sub-module: sync_edge (two-flop synchroniser plus rising-edge pulse, async active-low reset); instantiated once for LE.
REQ-037 Storage inferred as register array; no vendor primitives, CPLD-friendly.

Verification
REQ-038 Reset then single LE pulse with D=0xA5 -> VALID within 4 CLK, Q=0xA5, COUNT=1; RD -> VALID=0, Q=0x00.
REQ-039 Four LE pulses D=0x11,0x22,0x33,0x44 (DEPTH=4) -> FULL=1, COUNT=4; fifth pulse D=0x55 -> OVERRUN=1, four RDs return 0x11..0x44, 0x55 never seen.
REQ-040 FULL, capture D=0x66 coincident with RD -> COUNT stays 4, 0x11 popped, 0x66 later read last.
REQ-041 Empty, capture coincident with RD, D=0x77 -> COUNT=1, Q=0x77.
REQ-042 LE held high 20 CLK -> exactly one capture; nRESET pulsed low during sync stage of LE edge -> COUNT=0 after reset, no capture.
REQ-043 OVERRUN set, CLR_OVR asserted same cycle as another dropped capture -> OVERRUN stays 1; CLR_OVR alone next cycle -> OVERRUN=0; nOE toggling -> Q_OE = ~nOE, COUNT unchanged.

Source files
------------

// File: rtl/latch_pkg.sv
// Shared constants and helpers for the latch FIFO block.
package latch_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/latch_fifo_if.sv
// Host/consumer bus of the latch FIFO.
//
// Handshake: LE is a level strobe from the host, asynchronous to CLK; each
// rising edge requests exactly one capture of D. RD is a single-cycle pop
// acknowledge sampled on the rising CLK edge and is only honoured while
// VALID is high. Q presents the head entry whenever VALID is high and is
// 0 otherwise. Q_OE follows ~nOE and is the tri-state enable for Q.
interface latch_fifo_if
    import latch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] D;
    logic             LE;
    logic             RD;
    logic             CLR_OVR;
    logic             nOE;
    logic [WIDTH-1:0] Q;
    logic             Q_OE;
    logic             VALID;
    logic             FULL;
    logic [CW-1:0]    COUNT;
    logic             OVERRUN;

    modport master (
        output D, LE, RD, CLR_OVR, nOE,
        input  Q, Q_OE, VALID, FULL, COUNT, OVERRUN
    );

    modport slave (
        input  D, LE, RD, CLR_OVR, nOE,
        output Q, Q_OE, VALID, FULL, COUNT, OVERRUN
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge pulse generator.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // Synchroniser chain; reset presets every stage high so that a level
    // already high when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= level;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/latch_fifo.sv
// Latch FIFO: captures host data on each LE rising edge into a small
// register-array queue that a consumer drains with single-cycle RD pops.
module latch_fifo
    import latch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic        CLK,
    input logic        nRESET,
    latch_fifo_if.slave bus
);

    localparam int              AW       = clog2(DEPTH);
    localparam int              CW       = clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             ovr;
    logic             le_rise;
    logic             cap;
    logic             is_full;
    logic             is_empty;
    logic             pop;
    logic             push;
    logic             drop;

    sync_edge u_le_sync (
        .clk   (CLK),
        .rst_n (nRESET),
        .level (bus.LE),
        .pulse (le_rise)
    );

    // Capture event fires the cycle after the edge detect.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cap <= 1'b0;
        end else begin
            cap <= le_rise;
        end
    end

    // Queue decisions: a pop frees a slot for a coincident capture even when full.
    always_comb begin
        is_full  = (count == FULL_CNT);
        is_empty = (count == '0);
        pop      = bus.RD && !is_empty;
        push     = cap && (!is_full || pop);
        drop     = cap && is_full && !pop;
    end

    // Pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovr   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovr <= 1'b1;
            end else if (bus.CLR_OVR) begin
                ovr <= 1'b0;
            end
        end
    end

    // Storage write; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= bus.D;
        end
    end

    assign bus.Q       = is_empty ? '0 : mem[rptr];
    assign bus.Q_OE    = ~bus.nOE;
    assign bus.VALID   = !is_empty;
    assign bus.FULL    = is_full;
    assign bus.COUNT   = count;
    assign bus.OVERRUN = ovr;

endmodule

// File: tb/tb_latch_fifo.sv
// Directed bench for latch_fifo: a per-cycle vector table plus hand-written
// multi-cycle sequences for fill/overrun, full push+pop and reset corners.
module tb_latch_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] d;
        logic       le;
        logic       rd;
        logic       clr;
        logic       noe;
        logic       e_valid;
        logic       e_full;
        logic [2:0] e_count;
        logic [7:0] e_q;
        logic       e_ovr;
        logic       e_qoe;
    } vec_t;

    logic clk = 1'b0;
    logic nreset;
    int   checks = 0;
    int   failures = 0;
    vec_t vec [14];

    always #5 clk = ~clk;

    latch_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    latch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK    (clk),
        .nRESET (nreset),
        .bus    (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_valid, input logic e_full,
                              input logic [2:0] e_count, input logic [7:0] e_q, input logic e_ovr);
        chk({tag, ".valid"},   32'(bus.VALID),   32'(e_valid));
        chk({tag, ".full"},    32'(bus.FULL),    32'(e_full));
        chk({tag, ".count"},   32'(bus.COUNT),   32'(e_count));
        chk({tag, ".q"},       32'(bus.Q),       32'(e_q));
        chk({tag, ".overrun"}, 32'(bus.OVERRUN), 32'(e_ovr));
    endtask

    // Raise LE for two cycles with D held until the capture edge; optional
    // RD / CLR_OVR ride on the capture edge itself. Starts and ends at a negedge.
    task automatic capture(input logic [7:0] d, input logic rd, input logic clr);
        bus.D  = d;
        bus.LE = 1'b1;
        repeat (2) @(negedge clk);
        bus.LE = 1'b0;
        @(negedge clk);
        bus.RD      = rd;
        bus.CLR_OVR = clr;
        @(negedge clk);
        bus.RD      = 1'b0;
        bus.CLR_OVR = 1'b0;
        bus.D       = '0;
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        chk("pop.q", 32'(bus.Q), 32'(exp));
        bus.RD = 1'b1;
        @(negedge clk);
        bus.RD = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  found;

        //                d      le  rd  clr noe  valid full cnt q      ovr qoe
        vec[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[1]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[2]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[3]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'hA5, 1'b0, 1'b0};
        vec[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vec[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vec[7]  = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[8]  = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[9]  = '{8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[10] = '{8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h77, 1'b0, 1'b0};
        vec[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h77, 1'b0, 1'b1};
        vec[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vec[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};

        // Clock/reset
        nreset      = 1'b0;
        bus.D       = '0;
        bus.LE      = 1'b0;
        bus.RD      = 1'b0;
        bus.CLR_OVR = 1'b0;
        bus.nOE     = 1'b1;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Table: inputs applied at a negedge, outputs checked one cycle later
        for (int i = 0; i < 14; i++) begin
            bus.D       = vec[i].d;
            bus.LE      = vec[i].le;
            bus.RD      = vec[i].rd;
            bus.CLR_OVR = vec[i].clr;
            bus.nOE     = vec[i].noe;
            @(negedge clk);
            check_outs($sformatf("row%0d", i), vec[i].e_valid, vec[i].e_full,
                       vec[i].e_count, vec[i].e_q, vec[i].e_ovr);
            chk($sformatf("row%0d.q_oe", i), 32'(bus.Q_OE), 32'(vec[i].e_qoe));
        end
        bus.RD      = 1'b0;
        bus.CLR_OVR = 1'b0;
        bus.nOE     = 1'b1;

        // Fill to full, then one dropped capture
        capture(8'h11, 1'b0, 1'b0);
        check_outs("fill1", 1'b1, 1'b0, 3'd1, 8'h11, 1'b0);
        capture(8'h22, 1'b0, 1'b0);
        capture(8'h33, 1'b0, 1'b0);
        capture(8'h44, 1'b0, 1'b0);
        check_outs("fill4", 1'b1, 1'b1, 3'd4, 8'h11, 1'b0);
        capture(8'h55, 1'b0, 1'b0);
        check_outs("drop55", 1'b1, 1'b1, 3'd4, 8'h11, 1'b1);
        pop_expect(8'h11);
        pop_expect(8'h22);
        pop_expect(8'h33);
        pop_expect(8'h44);
        check_outs("drained", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

        // Refill; clear coincident with another drop, then clear alone
        capture(8'h11, 1'b0, 1'b0);
        capture(8'h22, 1'b0, 1'b0);
        capture(8'h33, 1'b0, 1'b0);
        capture(8'h44, 1'b0, 1'b0);
        capture(8'h88, 1'b0, 1'b1);
        check_outs("clr_vs_drop", 1'b1, 1'b1, 3'd4, 8'h11, 1'b1);
        bus.CLR_OVR = 1'b1;
        @(negedge clk);
        bus.CLR_OVR = 1'b0;
        check_outs("clr_alone", 1'b1, 1'b1, 3'd4, 8'h11, 1'b0);

        // Full: capture and pop on the same edge
        capture(8'h66, 1'b1, 1'b0);
        check_outs("full_push_pop", 1'b1, 1'b1, 3'd4, 8'h22, 1'b0);
        pop_expect(8'h22);
        pop_expect(8'h33);
        pop_expect(8'h44);
        pop_expect(8'h66);
        check_outs("empty_again", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        // LE held high for 20 cycles: one capture, VALID four edges after the rise
        bus.D  = 8'h99;
        bus.LE = 1'b1;
        found  = 1'b0;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!found && bus.VALID) begin
                found = 1'b1;
                lat   = i;
            end
        end
        bus.LE = 1'b0;
        repeat (4) @(negedge clk);
        chk("le_hold.seen", 32'(found), 32'd1);
        chk("le_hold.latency", 32'(lat), 32'd4);
        check_outs("le_hold", 1'b1, 1'b0, 3'd1, 8'h99, 1'b0);

        // Reset while an LE edge is in the synchroniser, LE still high at release
        bus.D  = 8'hAB;
        bus.LE = 1'b1;
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (6) @(negedge clk);
        check_outs("rst_le_high", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        bus.LE = 1'b0;
        repeat (4) @(negedge clk);
        check_outs("rst_le_low", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        capture(8'h5A, 1'b0, 1'b0);
        check_outs("post_rst", 1'b1, 1'b0, 3'd1, 8'h5A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
